// File: rtl/breadboard_pkg.sv
// Shared definitions for the breadboard traffic-light controller:
// mode encodings, car light indices, car phases and lane byte offsets.
package breadboard_pkg;

  // Controller mode, exactly as it appears on trafficMode.
  typedef enum logic [1:0] {
    MODE_DAY   = 2'b00,
    MODE_NIGHT = 2'b01,
    MODE_PED   = 2'b10,
    MODE_EMG   = 2'b11
  } mode_t;

  // Car phase ring position.
  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  // Bit positions of each lane's light in dayTimeLightOutput.
  localparam int LIGHT_S1 = 0;
  localparam int LIGHT_S2 = 1;
  localparam int LIGHT_E1 = 2;
  localparam int LIGHT_E2 = 3;
  localparam int LIGHT_N1 = 4;
  localparam int LIGHT_N2 = 5;
  localparam int LIGHT_W1 = 6;
  localparam int LIGHT_W2 = 7;

  // Low bit of each lane's 8-bit car count inside the packed lanes bus.
  localparam int LANE_W1 = 56;
  localparam int LANE_W2 = 48;
  localparam int LANE_S1 = 40;
  localparam int LANE_S2 = 32;
  localparam int LANE_E1 = 24;
  localparam int LANE_E2 = 16;
  localparam int LANE_N1 = 8;
  localparam int LANE_N2 = 0;

  // Car light pattern for a given phase: two opposing lanes go green.
  function automatic logic [7:0] phase_lights(input phase_t p);
    logic [7:0] l;
    l = 8'h00;
    case (p)
      P0: begin l[LIGHT_S1] = 1'b1; l[LIGHT_N1] = 1'b1; end
      P1: begin l[LIGHT_S2] = 1'b1; l[LIGHT_N2] = 1'b1; end
      P2: begin l[LIGHT_E1] = 1'b1; l[LIGHT_W1] = 1'b1; end
      default: begin l[LIGHT_E2] = 1'b1; l[LIGHT_W2] = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/breadboard_phase_timer.sv
// Phase length down-counter: a load starts a phase of loadIn cycles,
// hold freezes the count, otherwise it counts down and rests at zero.
module phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] loadIn,
  input  logic       load,
  input  logic       hold,
  output logic [6:0] currentCount,
  output logic       isZero
);

  assign isZero = (currentCount == 7'd0);

  // Load loadIn-1 so the phase spans exactly loadIn cycles including the load cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      currentCount <= 7'd0;
    end else if (load) begin
      currentCount <= loadIn - 7'd1;
    end else if (hold) begin
      currentCount <= currentCount;
    end else if (!isZero) begin
      currentCount <= currentCount - 7'd1;
    end
  end

endmodule

// File: rtl/breadboard.sv
// Four-way intersection controller: sequences car phases, pedestrian
// and emergency modes, computes phase lengths and drives registered lights.
module breadboard
  import breadboard_pkg::*;
#(
  parameter int DAY_START  = 6,
  parameter int DAY_END    = 19,
  parameter int PED_TIME   = 15,
  parameter int EMG_TIME   = 20,
  parameter int NIGHT_TIME = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hoursIn,
  input  logic        pedSignal,
  input  logic        emgSignal,
  input  logic [7:0]  emgLane,
  input  logic [63:0] lanes,
  output logic [7:0]  dayTimeLightOutput,
  output logic [7:0]  walkingLightOutput,
  output logic [1:0]  trafficMode,
  output logic [6:0]  currentCount
);

  mode_t      mode, next_mode;
  phase_t     phase, next_phase, ring_phase;
  logic [1:0] ring_idx;
  logic       ped_latch, next_ped;
  logic [7:0] car, next_car;
  logic [7:0] walk, next_walk;
  logic       dayNightSignal;
  logic       isZero;
  logic       emgLoad, emg_hold;
  logic       load;
  logic [6:0] loadIn;
  logic [6:0] day_load;
  logic [7:0] count_a, count_b, max_count;

  assign dayNightSignal = (hoursIn >= 5'(DAY_START)) && (hoursIn <= 5'(DAY_END));
  assign ring_idx       = phase + 2'd1;
  assign ring_phase     = phase_t'(ring_idx);

  assign trafficMode        = mode;
  assign dayTimeLightOutput = car;
  assign walkingLightOutput = walk;

  phase_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .loadIn       (loadIn),
    .load         (load),
    .hold         (emg_hold),
    .currentCount (currentCount),
    .isZero       (isZero)
  );

  // Day phase length from the busier of the two lanes the next phase serves.
  always_comb begin
    count_a = 8'h00;
    count_b = 8'h00;
    case (ring_phase)
      P0: begin count_a = lanes[LANE_S1 +: 8]; count_b = lanes[LANE_N1 +: 8]; end
      P1: begin count_a = lanes[LANE_S2 +: 8]; count_b = lanes[LANE_N2 +: 8]; end
      P2: begin count_a = lanes[LANE_E1 +: 8]; count_b = lanes[LANE_W1 +: 8]; end
      default: begin count_a = lanes[LANE_E2 +: 8]; count_b = lanes[LANE_W2 +: 8]; end
    endcase
    max_count = (count_a > count_b) ? count_a : count_b;
    day_load  = 7'd4 + {2'b00, max_count[7:3]};
  end

  // Next mode, phase, load time, pedestrian latch and light decode.
  always_comb begin
    next_mode  = mode;
    next_phase = phase;
    next_ped   = ped_latch;
    next_car   = car;
    next_walk  = walk;
    loadIn     = 7'(EMG_TIME);

    // An active emergency keeps the count pinned at its top value; any other
    // emergency cycle (preempt or boundary) reloads it.
    emg_hold = emgSignal && (mode == MODE_EMG) && (currentCount == 7'(EMG_TIME - 1));
    emgLoad  = emgSignal && !emg_hold;
    load     = emgLoad || isZero;

    if (pedSignal && (mode != MODE_PED)) begin
      next_ped = 1'b1;
    end

    if (emgSignal) begin
      next_mode = MODE_EMG;
      loadIn    = 7'(EMG_TIME);
    end else if (isZero) begin
      if (ped_latch) begin
        next_mode = MODE_PED;
        loadIn    = 7'(PED_TIME);
        next_ped  = 1'b0;
      end else begin
        next_phase = ring_phase;
        if (dayNightSignal) begin
          next_mode = MODE_DAY;
          loadIn    = day_load;
        end else begin
          next_mode = MODE_NIGHT;
          loadIn    = 7'(NIGHT_TIME);
        end
      end
    end

    case (next_mode)
      MODE_EMG: begin
        next_car  = emgLane;
        next_walk = 8'h00;
      end
      MODE_PED: begin
        next_car  = 8'h00;
        next_walk = 8'hFF;
      end
      default: begin
        next_car  = phase_lights(next_phase);
        next_walk = 8'h00;
      end
    endcase
  end

  // State and output registers; reset parks the ring on P3 so P0 comes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode      <= MODE_DAY;
      phase     <= P3;
      ped_latch <= 1'b0;
      car       <= 8'h00;
      walk      <= 8'h00;
    end else begin
      mode      <= next_mode;
      phase     <= next_phase;
      ped_latch <= next_ped;
      car       <= next_car;
      walk      <= next_walk;
    end
  end

endmodule

// File: tb/tb_breadboard.sv
// Directed, table-driven bench for the breadboard traffic controller.
module tb_breadboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hoursIn;
  logic        pedSignal;
  logic        emgSignal;
  logic [7:0]  emgLane;
  logic [63:0] lanes;
  logic [7:0]  dayTimeLightOutput;
  logic [7:0]  walkingLightOutput;
  logic [1:0]  trafficMode;
  logic [6:0]  currentCount;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        rst;
    logic [4:0]  hours;
    logic        ped;
    logic        emg;
    logic [7:0]  lane;
    logic [63:0] lanes;
    int          n;
    logic [1:0]  mode;
    logic [7:0]  car;
    logic [7:0]  walk;
    logic [6:0]  count;
  } vec_t;

  vec_t vecs[$];

  breadboard dut (
    .clk                (clk),
    .rst                (rst),
    .hoursIn            (hoursIn),
    .pedSignal          (pedSignal),
    .emgSignal          (emgSignal),
    .emgLane            (emgLane),
    .lanes              (lanes),
    .dayTimeLightOutput (dayTimeLightOutput),
    .walkingLightOutput (walkingLightOutput),
    .trafficMode        (trafficMode),
    .currentCount       (currentCount)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic logic [63:0] mkLanes(input logic [7:0] w1, w2, s1, s2, e1, e2, n1, n2);
    return {w1, w2, s1, s2, e1, e2, n1, n2};
  endfunction

  task automatic addVec(input logic r, input logic [4:0] h, input logic p, input logic e,
                        input logic [7:0] el, input logic [63:0] ln, input int n,
                        input logic [1:0] m, input logic [7:0] c, input logic [7:0] w,
                        input logic [6:0] cnt);
    vec_t v;
    v.rst = r; v.hours = h; v.ped = p; v.emg = e; v.lane = el; v.lanes = ln; v.n = n;
    v.mode = m; v.car = c; v.walk = w; v.count = cnt;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic checkAll(input int idx, input logic [1:0] m, input logic [7:0] c,
                          input logic [7:0] w, input logic [6:0] cnt);
    checkOutput("trafficMode", idx, {6'b0, trafficMode}, {6'b0, m});
    checkOutput("carLights", idx, dayTimeLightOutput, c);
    checkOutput("walkLights", idx, walkingLightOutput, w);
    checkOutput("currentCount", idx, {1'b0, currentCount}, {1'b0, cnt});
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    hoursIn   = v.hours;
    pedSignal = v.ped;
    emgSignal = v.emg;
    emgLane   = v.lane;
    lanes     = v.lanes;
    repeat (v.n) step();
  endtask

  initial begin
    logic [63:0] l1, z;
    int waited;
    l1 = mkLanes(8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00);
    z  = 64'h0;

    // reset, then day from s1/n1 counts
    addVec(1, 12, 0, 0, 8'h00, l1, 2,  2'b00, 8'h00, 8'h00, 0);
    addVec(0, 12, 0, 0, 8'h00, l1, 1,  2'b00, 8'h11, 8'h00, 18);
    addVec(0, 12, 0, 0, 8'h00, l1, 18, 2'b00, 8'h11, 8'h00, 0);
    addVec(0, 12, 0, 0, 8'h00, l1, 1,  2'b00, 8'h22, 8'h00, 3);
    // hour change waits for the boundary, then night ring
    addVec(0, 2, 0, 0, 8'h00, z, 3,  2'b00, 8'h22, 8'h00, 0);
    addVec(0, 2, 0, 0, 8'h00, z, 1,  2'b01, 8'h44, 8'h00, 7);
    addVec(0, 2, 0, 0, 8'h00, z, 8,  2'b01, 8'h88, 8'h00, 7);
    addVec(0, 2, 0, 0, 8'h00, z, 8,  2'b01, 8'h11, 8'h00, 7);
    addVec(0, 2, 0, 0, 8'h00, z, 8,  2'b01, 8'h22, 8'h00, 7);
    // back to day, pedestrian pulse mid-P0
    addVec(0, 12, 0, 0, 8'h00, z, 8,  2'b00, 8'h44, 8'h00, 3);
    addVec(0, 12, 0, 0, 8'h00, z, 4,  2'b00, 8'h88, 8'h00, 3);
    addVec(0, 12, 0, 0, 8'h00, z, 4,  2'b00, 8'h11, 8'h00, 3);
    addVec(0, 12, 1, 0, 8'h00, z, 1,  2'b00, 8'h11, 8'h00, 2);
    addVec(0, 12, 0, 0, 8'h00, z, 2,  2'b00, 8'h11, 8'h00, 0);
    addVec(0, 12, 0, 0, 8'h00, z, 1,  2'b10, 8'h00, 8'hFF, 14);
    addVec(0, 12, 1, 0, 8'h00, z, 14, 2'b10, 8'h00, 8'hFF, 0);
    addVec(0, 12, 0, 0, 8'h00, z, 1,  2'b00, 8'h22, 8'h00, 3);
    // emergency preempt, hold, lane change, release
    addVec(0, 12, 0, 0, 8'h00, z, 1,  2'b00, 8'h22, 8'h00, 2);
    addVec(0, 12, 0, 1, 8'h08, z, 1,  2'b11, 8'h08, 8'h00, 19);
    addVec(0, 12, 0, 1, 8'h08, z, 5,  2'b11, 8'h08, 8'h00, 19);
    addVec(0, 12, 0, 1, 8'h30, z, 1,  2'b11, 8'h30, 8'h00, 19);
    addVec(0, 12, 0, 0, 8'h30, z, 1,  2'b11, 8'h30, 8'h00, 18);
    addVec(0, 12, 0, 0, 8'h30, z, 18, 2'b11, 8'h30, 8'h00, 0);
    addVec(0, 12, 0, 0, 8'h30, z, 1,  2'b00, 8'h44, 8'h00, 3);
    // emergency and pedestrian together at a boundary
    addVec(0, 12, 0, 0, 8'h00, z, 3,  2'b00, 8'h44, 8'h00, 0);
    addVec(0, 12, 1, 1, 8'h01, z, 1,  2'b11, 8'h01, 8'h00, 19);
    addVec(0, 12, 0, 0, 8'h01, z, 1,  2'b11, 8'h01, 8'h00, 18);
    addVec(0, 12, 0, 0, 8'h01, z, 18, 2'b11, 8'h01, 8'h00, 0);
    addVec(0, 12, 0, 0, 8'h00, z, 1,  2'b10, 8'h00, 8'hFF, 14);
    addVec(0, 12, 0, 0, 8'h00, z, 14, 2'b10, 8'h00, 8'hFF, 0);
    addVec(0, 12, 0, 0, 8'h00, z, 1,  2'b00, 8'h88, 8'h00, 3);
    // reset during emergency, with a pending pedestrian request it must drop
    addVec(0, 12, 1, 1, 8'h80, z, 1,  2'b11, 8'h80, 8'h00, 19);
    addVec(1, 12, 0, 1, 8'h80, z, 1,  2'b00, 8'h00, 8'h00, 0);
    addVec(0, 12, 0, 0, 8'h00, z, 1,  2'b00, 8'h11, 8'h00, 3);
    // long day phases, including the maximum load of 35
    addVec(0, 12, 0, 0, 8'h00, mkLanes(0, 0, 0, 8'hF0, 0, 0, 0, 8'h10), 4, 2'b00, 8'h22, 8'h00, 33);
    addVec(0, 12, 0, 0, 8'h00, mkLanes(0, 0, 0, 0, 8'hFF, 0, 0, 0), 34, 2'b00, 8'h44, 8'h00, 34);
    // hour boundaries: 24 and 5 are night, 19 and 6 are day
    addVec(0, 24, 0, 0, 8'h00, z, 35, 2'b01, 8'h88, 8'h00, 7);
    addVec(0, 19, 0, 0, 8'h00, z, 8,  2'b00, 8'h11, 8'h00, 3);
    addVec(0, 5,  0, 0, 8'h00, z, 4,  2'b01, 8'h22, 8'h00, 7);
    addVec(0, 6,  0, 0, 8'h00, z, 8,  2'b00, 8'h44, 8'h00, 3);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkAll(i, vecs[i].mode, vecs[i].car, vecs[i].walk, vecs[i].count);
    end

    // pedestrian pulse, bounded wait for the walk phase
    pedSignal = 1'b1;
    step();
    pedSignal = 1'b0;
    waited = 0;
    while (trafficMode != 2'b10 && waited < 40) begin
      step();
      waited++;
    end
    checkOutput("pedWaitCycles", 100, 8'(waited), 8'd3);
    checkAll(101, 2'b10, 8'h00, 8'hFF, 14);

    // emergency from pedestrian mode, count pinned while held
    emgSignal = 1'b1;
    emgLane   = 8'h0F;
    step();
    checkAll(102, 2'b11, 8'h0F, 8'h00, 19);
    for (int k = 0; k < 6; k++) begin
      step();
      checkOutput("emgHoldCount", 103 + k, {1'b0, currentCount}, 8'd19);
    end
    emgSignal = 1'b0;
    step();
    checkAll(110, 2'b11, 8'h0F, 8'h00, 18);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/breadboard.md
# breadboard

Top-level four-way-intersection traffic-light controller. It times eight car-lane green lights and eight pedestrian walk lights from per-lane car counts, time of day, pedestrian requests and emergency-vehicle requests. It sits directly under the simulation bench. All outputs are registered.

## Interface
Parameters:
- DAY_START, default 6: first hour (inclusive) treated as day.
- DAY_END, default 19: last hour (inclusive) treated as day.
- PED_TIME, default 15: pedestrian phase length, in cycles.
- EMG_TIME, default 20: minimum emergency phase length, in cycles.
- NIGHT_TIME, default 8: fixed night green length, in cycles.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- hoursIn, input, 5: hour of day, 0–23. Values 24–31 are treated as night.
- pedSignal, input, 1: pedestrian request. Sampled every cycle and latched.
- emgSignal, input, 1: emergency request. Level-sensitive.
- emgLane, input, 8: one-hot (or multi-hot) mask of light indices to turn green during an emergency.
- lanes, input, 64: packed 8-bit car counts, {w1,w2,s1,s2,e1,e2,n1,n2}, where w1=[63:56] and n2=[7:0].
- dayTimeLightOutput, output, 8: car green lights (1 = green). Index map: 0=s1, 1=s2, 2=e1, 3=e2, 4=n1, 5=n2, 6=w1, 7=w2.
- walkingLightOutput, output, 8: walk lights (1 = walk).
- trafficMode, output, 2: current mode. 00 = day, 01 = night, 10 = pedestrian, 11 = emergency.
- currentCount, output, 7: remaining cycles in the current phase.

## Operation
- dayNightSignal is combinational: it is 1 when DAY_START ≤ hoursIn ≤ DAY_END.
- The controller steps through four car phases in a ring:
  - P0: s1 and n1 green.
  - P1: s2 and n2 green.
  - P2: e1 and w1 green.
  - P3: e2 and w2 green.
  - All other car lights are 0.
- Load times:
  - dayLoadTime = 4 + (max count of the two next-phase lanes >> 3). Range 4–35.
  - nightLoadTime = NIGHT_TIME.
  - pedLoadTime = PED_TIME.
  - emgLoadTime = EMG_TIME.
- Boundary selection: when isZero (currentCount == 0), the next mode is chosen by priority:
  - emergency, if emgSignal = 1;
  - else pedestrian, if the pedestrian request latch is set;
  - else day if dayNightSignal = 1, otherwise night.
- loadIn is the load time of the selected mode. currentCount loads loadIn−1, so every phase lasts exactly loadIn cycles.
- Day or night boundary: the car phase advances P(n) → P(n+1 mod 4). Lights update for the new phase on the same edge.
- Pedestrian mode:
  - All car lights 0 and all walk lights 1.
  - The request latch clears on entry.
  - On exit, the ring resumes at the phase after the last car phase served.
- Emergency mode:
  - Car lights = emgLane; walk lights 0.
  - Emergency preempts immediately: when emgSignal rises mid-phase, on the next edge the mode becomes 11 and currentCount loads EMG_TIME−1. This load is driven by emgLoad.
  - The count is held at EMG_TIME−1 while emgSignal stays 1, then counts down after release.
  - emgLane changes while in emergency are reflected on the next edge.
- In day and night modes, all walk lights are 0.
- Otherwise, currentCount decrements by 1 per cycle.

## Timing
- Reset (rst = 1 at an edge) sets:
  - currentCount = 0, car phase = P3, trafficMode = 00;
  - dayTimeLightOutput = 0, walkingLightOutput = 0;
  - pedestrian latch cleared.
- Reset has priority over every other input, including mid-phase and mid-emergency.
- First edge after reset release: isZero, so the controller enters P0 (or a higher-priority mode) with its load time.
- pedSignal asserted for one cycle anywhere in a phase is served at the next boundary. Repeated requests during pedestrian mode are not re-latched.
- emgSignal and pedSignal together at a boundary: emergency wins; the pedestrian latch is retained.
- An hoursIn change takes effect only at the next boundary.
- All widths are unsigned. dayLoadTime never exceeds 35, so it fits 7 bits.

## Structure
- Shared package holds:
  - the mode encodings MODE_DAY/NIGHT/PED/EMG;
  - the light index constants;
  - the phase enum P0–P3;
  - the lane-unpack offsets.
- One natural sub-module, phase_timer: 7-bit down-counter with inputs loadIn, load and hold, and outputs currentCount and isZero.
- Mode and phase sequencing, load-time computation and light decode live in breadboard.

## Test plan
- Reset, then day: rst=1 for 2 cycles with hoursIn=12 and s1=0x7F, n1=0x07.
  - During reset: all outputs 0.
  - First edge after release: trafficMode=00, lights=0x11 (indices 0 and 4 set), currentCount=18 (load 4+15=19).
  - Next boundary after 19 cycles: lights=0x22.
- Night: hoursIn=2, all lanes 0.
  - Each phase lasts 8 cycles, trafficMode=01.
  - Lights cycle 0x11 → 0x22 → 0x44 → 0x88 → 0x11.
- Pedestrian: pulse pedSignal one cycle mid-P0 in day mode.
  - At the P0 boundary: trafficMode=10, car lights 0, walk lights 0xFF for 15 cycles.
  - Then P1 with lights 0x22.
- Emergency preempt: emgSignal=1 with emgLane=0x08 mid-phase.
  - Next edge: trafficMode=11, lights=0x08, currentCount=19, held while asserted.
  - After release: 20 cycles, then the normal boundary.
- Priority: emgSignal and pedSignal both 1 at a boundary.
  - Emergency is served first; pedestrian follows at the boundary after the emergency ends.
- Mid-operation reset: assert rst during emergency.
  - Next edge: all outputs 0, trafficMode=00.
